vote_accumulator: RTL and testbench
===================================

Name: vote_accumulator

Overview:
- Parametrised per-class vote accumulator with argmax selection, for the classifier back end after the final flatten/compare stage.
- Each input beat carries one hit bit per class; every hit increments that class's saturating counter.
- On frame end, a sequential scan picks the winning class and reports its count, a tie flag, and a one-cycle result strobe.
- Generalises the fixed 11-class, 8-bit, unhandshaked counter to N classes, a configurable width, a valid/ready handshake, saturation, and argmax.

Parameters:
- NUM_CLASSES, 11, number of classes/counters (>=2).
- CNT_W, 8, counter width in bits.
- AUTO_CLEAR, 1, 1 = counters zeroed after each result; 0 = counters persist until `clear`.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counters and sat; aborts scan.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beats (high only in ACCUM).
- in_hit  in  NUM_CLASSES  bit i = class i voted this beat; multi-hot legal.
- frame_end  in  1  close frame; legal with or without in_valid.
- counts  out  NUM_CLASSES*CNT_W  flattened counters; class i at [i*CNT_W +: CNT_W].
- busy  out  1  high in SCAN or DONE.
- res_valid  out  1  one-cycle result strobe.
- res_class  out  CLS_W  winning class index, CLS_W = max(1,$clog2(NUM_CLASSES)).
- res_count  out  CNT_W  winner's count.
- res_tie  out  1  another class equals the winner's count.
- sat  out  1  sticky: some counter saturated since last clear/reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=ACCUM; all counters 0; res_valid/res_class/res_count/res_tie/sat=0; scan index and best registers 0.
- States: ACCUM -> SCAN -> DONE -> ACCUM.
- ACCUM:
  - in_ready=1, busy=0.
  - Accepted beat = in_valid&&in_ready. For each i with in_hit[i]=1, counter i += 1 on the next edge.
  - At all-ones a counter holds and sets sat=1. Saturation is per counter; others still increment.
  - Non-hit counters are unchanged. in_hit is ignored when in_valid=0.
  - frame_end=1: any same-cycle accepted beat is applied first, then next state=SCAN; idx=0, best_cnt=0, best_idx=0, tie=0.
- SCAN:
  - in_ready=0, busy=1. Examines one class per cycle, idx 0..NUM_CLASSES-1, so it takes exactly NUM_CLASSES cycles.
  - cnt[idx] > best_cnt, or idx==0: best_cnt=cnt[idx], best_idx=idx, tie=0.
  - cnt[idx]==best_cnt with idx>0: tie=1.
  - Strict compare, so the lowest index wins ties. All-zero counts -> class 0, count 0, tie=1.
  - After idx=NUM_CLASSES-1 -> DONE.
- DONE (one cycle):
  - res_valid=1; res_class/res_count/res_tie loaded from best regs.
  - The res_* values are held after the strobe until the next DONE or reset.
  - If AUTO_CLEAR=1, counters zero on exit; sat is kept. Next state ACCUM.
- Latency: frame_end accepted at cycle T -> res_valid at cycle T+NUM_CLASSES+1; in_ready high again at T+NUM_CLASSES+2.
- clear:
  - Priority over everything except reset. Zeroes counters and sat; state=ACCUM.
  - Any in-flight scan is dropped: no res_valid, res_* keep their old values.
  - A beat or frame_end in the same cycle as clear is discarded.
- frame_end while busy: ignored (in_ready=0). in_valid while busy: not accepted; upstream must hold it.
- counts is a direct register view, updated one edge after acceptance.

Decomposition:
- Package vote_pkg:
  - typedef enum logic [1:0] {ACCUM, SCAN, DONE} vote_state_t;
  - function clog2_min1 for CLS_W.
- Sub-module vote_sat_counter (CNT_W):
  - Ports: clock, reset_n, clr, inc, cnt, sat_hit.
  - Instantiated NUM_CLASSES times by generate.
- Top level holds the FSM, argmax datapath and result registers.

Test Plan:
- Reset/idle: reset_n low mid-beat -> all counts 0, res_valid=0, in_ready=1 one cycle after release; no spurious res_valid.
- Basic vote: defaults; beats with hit masks class3, class3, class7, class3 then frame_end -> res_valid at T+12 with res_class=3, res_count=3, res_tie=0; counts zero afterwards.
- Saturation: CNT_W=4, 20 beats hitting class 5 plus class 0 once -> count5=15, count0=1, sat=1; result class 5, count 15.
- Tie and zero frame: classes 2 and 9 each hit 4 times -> res_class=2, res_tie=1. Empty frame -> res_class=0, res_count=0, res_tie=1.
- Handshake, same-cycle end and backpressure:
  - in_valid+frame_end with hit on class 1, after 2 prior class-6 hits -> winner 6, count 2, with class 1 counted as 1.
  - in_valid held during busy -> not accepted (in_ready=0) until ACCUM.
- Clear mid-scan and persistence:
  - clear at scan cycle 4 -> no res_valid, counts 0, previous res_* unchanged.
  - AUTO_CLEAR=0, two frames of 2 class-4 hits each -> second result count 4.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote accumulator.
package vote_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } vote_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vote_sat_counter.sv
// Single saturating up-counter; flags an increment attempted while already at all-ones.
module vote_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max_s;

    assign at_max_s = (cnt_q == {CNT_W{1'b1}});
    assign sat_hit  = inc && at_max_s && !clr;
    assign cnt      = cnt_q;

    // Next count: clear wins, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && !at_max_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vote_accumulator.sv
// Per-class saturating vote accumulator with a sequential argmax over the counters.
// One class is examined per scan cycle; the strict compare lets the lowest index win ties.
module vote_accumulator
    import vote_pkg::*;
#(
    parameter  int NUM_CLASSES = 11,
    parameter  int CNT_W       = 8,
    parameter  int AUTO_CLEAR  = 1,
    localparam int CLS_W       = clog2_min1(NUM_CLASSES)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CLASSES-1:0]       in_hit,
    input  logic                         frame_end,
    output logic [NUM_CLASSES*CNT_W-1:0] counts,
    output logic                         busy,
    output logic                         res_valid,
    output logic [CLS_W-1:0]             res_class,
    output logic [CNT_W-1:0]             res_count,
    output logic                         res_tie,
    output logic                         sat
);

    vote_state_t             state_q;
    logic [CLS_W-1:0]        idx_q;
    logic [CLS_W-1:0]        best_idx_q;
    logic [CLS_W-1:0]        best_idx_d;
    logic [CNT_W-1:0]        best_cnt_q;
    logic [CNT_W-1:0]        best_cnt_d;
    logic                    tie_q;
    logic                    tie_d;
    logic                    res_valid_q;
    logic [CLS_W-1:0]        res_class_q;
    logic [CNT_W-1:0]        res_count_q;
    logic                    res_tie_q;
    logic                    sat_q;
    logic                    sat_d;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    accept_s;
    logic                    clr_s;
    logic                    last_s;
    logic [CNT_W-1:0]        cur_cnt_s;
    logic [NUM_CLASSES-1:0]  inc_s;
    logic [NUM_CLASSES-1:0]  sat_hit_s;
    logic [CNT_W-1:0]        cnt_s [NUM_CLASSES];

    assign accept_s  = in_valid && in_ready_q && !clear;
    assign clr_s     = clear || ((AUTO_CLEAR != 0) && (state_q == DONE));
    assign inc_s     = {NUM_CLASSES{accept_s}} & in_hit;
    assign cur_cnt_s = cnt_s[idx_q];
    assign last_s    = (idx_q == CLS_W'(NUM_CLASSES - 1));

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        vote_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr_s),
            .inc     (inc_s[g]),
            .cnt     (cnt_s[g]),
            .sat_hit (sat_hit_s[g])
        );
        assign counts[g*CNT_W +: CNT_W] = cnt_s[g];
    end

    // Argmax step for the class currently under the scan index.
    always_comb begin
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        tie_d      = tie_q;
        if ((idx_q == {CLS_W{1'b0}}) || (cur_cnt_s > best_cnt_q)) begin
            best_cnt_d = cur_cnt_s;
            best_idx_d = idx_q;
            tie_d      = 1'b0;
        end else if (cur_cnt_s == best_cnt_q) begin
            tie_d = 1'b1;
        end else begin
            tie_d = tie_q;
        end
    end

    // Sticky saturation flag, dropped only by clear or reset.
    always_comb begin
        sat_d = sat_q;
        if (clear) begin
            sat_d = 1'b0;
        end else if (|sat_hit_s) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_q;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    // Frame FSM with scan datapath and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            idx_q       <= {CLS_W{1'b0}};
            best_cnt_q  <= {CNT_W{1'b0}};
            best_idx_q  <= {CLS_W{1'b0}};
            tie_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= {CLS_W{1'b0}};
            res_count_q <= {CNT_W{1'b0}};
            res_tie_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= ACCUM;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    res_valid_q <= 1'b0;
                    if (frame_end) begin
                        state_q    <= SCAN;
                        idx_q      <= {CLS_W{1'b0}};
                        best_cnt_q <= {CNT_W{1'b0}};
                        best_idx_q <= {CLS_W{1'b0}};
                        tie_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    best_cnt_q <= best_cnt_d;
                    best_idx_q <= best_idx_d;
                    tie_q      <= tie_d;
                    // Results take the final step's values so the strobe lines up with DONE.
                    if (last_s) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_class_q <= best_idx_d;
                        res_count_q <= best_cnt_d;
                        res_tie_q   <= tie_d;
                    end else begin
                        idx_q <= idx_q + {{(CLS_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_q     <= ACCUM;
                    res_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ACCUM;
                    res_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_count = res_count_q;
    assign res_tie   = res_tie_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_vote_accumulator.sv
// Bench for vote_accumulator: a default instance and a narrow non-auto-clearing one share stimulus.
module tb_vote_accumulator;

    localparam int NC = 11;
    localparam int W0 = 8;
    localparam int W1 = 4;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic frame_end = 1'b0;
    logic [NC-1:0] in_hit = '0;

    logic in_ready0, busy0, res_valid0, res_tie0, sat0;
    logic [NC*W0-1:0] counts0;
    logic [CW-1:0] res_class0;
    logic [W0-1:0] res_count0;
    logic in_ready1, busy1, res_valid1, res_tie1, sat1;
    logic [NC*W1-1:0] counts1;
    logic [CW-1:0] res_class1;
    logic [W1-1:0] res_count1;

    vote_accumulator #(.NUM_CLASSES(NC), .CNT_W(W0), .AUTO_CLEAR(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready0), .in_hit(in_hit), .frame_end(frame_end), .counts(counts0),
        .busy(busy0), .res_valid(res_valid0), .res_class(res_class0),
        .res_count(res_count0), .res_tie(res_tie0), .sat(sat0)
    );

    vote_accumulator #(.NUM_CLASSES(NC), .CNT_W(W1), .AUTO_CLEAR(0)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready1), .in_hit(in_hit), .frame_end(frame_end), .counts(counts1),
        .busy(busy1), .res_valid(res_valid1), .res_class(res_class1),
        .res_count(res_count1), .res_tie(res_tie1), .sat(sat1)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int m0 [NC];
    int m1 [NC];
    bit ms0, ms1;
    int p0c, p0n, p0t, p1c, p1n, p1t;

    typedef struct {
        logic [3:0][NC-1:0] h;
        int cls;
        int cnt;
        int tie;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] oh(input int i);
        logic [NC-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_zero0();
        for (int i = 0; i < NC; i++) m0[i] = 0;
    endtask

    task automatic model_zero_all();
        for (int i = 0; i < NC; i++) begin
            m0[i] = 0;
            m1[i] = 0;
        end
        ms0 = 1'b0;
        ms1 = 1'b0;
    endtask

    task automatic model_beat(input logic [NC-1:0] h);
        for (int i = 0; i < NC; i++) begin
            if (h[i]) begin
                if (m0[i] == (1 << W0) - 1) ms0 = 1'b1; else m0[i]++;
                if (m1[i] == (1 << W1) - 1) ms1 = 1'b1; else m1[i]++;
            end
        end
    endtask

    function automatic logic [NC*W0-1:0] flat0();
        logic [NC*W0-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*W0 +: W0] = W0'(m0[i]);
        return r;
    endfunction

    function automatic logic [NC*W1-1:0] flat1();
        logic [NC*W1-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*W1 +: W1] = W1'(m1[i]);
        return r;
    endfunction

    // Winner = first index holding the maximum; tie = maximum held more than once.
    function automatic void argmax(input int a [NC], output int cls, output int cnt, output int tie);
        int mx, n;
        mx = a[0];
        for (int i = 1; i < NC; i++) if (a[i] > mx) mx = a[i];
        n = 0;
        cls = -1;
        for (int i = 0; i < NC; i++) begin
            if (a[i] == mx) begin
                n++;
                if (cls < 0) cls = i;
            end
        end
        cnt = mx;
        tie = (n > 1) ? 1 : 0;
    endfunction

    task automatic drive(input logic v, input logic [NC-1:0] h, input logic fe);
        @(negedge clock);
        in_valid = v;
        in_hit = h;
        frame_end = fe;
    endtask

    task automatic beat(input logic [NC-1:0] h);
        drive(1'b1, h, 1'b0);
        @(posedge clock);
        model_beat(h);
    endtask

    task automatic start_frame(input logic v, input logic [NC-1:0] h);
        drive(v, h, 1'b1);
        @(posedge clock);
        if (v) model_beat(h);
    endtask

    task automatic wait_result(input logic hv, input logic [NC-1:0] hh);
        int k;
        bit ok_hs;
        int c0, n0, t0, c1, n1, t1;
        argmax(m0, c0, n0, t0);
        argmax(m1, c1, n1, t1);
        drive(hv, hh, 1'b0);
        check("scan_counts0", counts0, flat0());
        check("scan_counts1", counts1, flat1());
        k = 1;
        ok_hs = 1'b1;
        while (res_valid0 !== 1'b1 && k < 40) begin
            if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) ok_hs = 1'b0;
            @(negedge clock);
            k++;
        end
        check("latency", k, NC + 1);
        check("busy_handshake", ok_hs, 1'b1);
        check("res_valid1", res_valid1, 1'b1);
        check("res_class0", res_class0, c0);
        check("res_count0", res_count0, n0);
        check("res_tie0", res_tie0, t0);
        check("res_class1", res_class1, c1);
        check("res_count1", res_count1, n1);
        check("res_tie1", res_tie1, t1);
        check("sat0", sat0, ms0);
        check("sat1", sat1, ms1);
        @(negedge clock);
        check("after_done", {in_ready0, in_ready1, res_valid0, res_valid1}, 4'b1100);
        model_zero0();
        check("after_counts0", counts0, flat0());
        check("after_counts1", counts1, flat1());
        if (hv) begin
            @(posedge clock);
            model_beat(hh);
            drive(1'b0, '0, 1'b0);
            check("held_counts0", counts0, flat0());
            check("held_counts1", counts1, flat1());
        end
        p0c = c0; p0n = n0; p0t = t0;
        p1c = c1; p1n = n1; p1t = t1;
    endtask

    task automatic finish_frame(input logic v, input logic [NC-1:0] h);
        start_frame(v, h);
        wait_result(1'b0, '0);
    endtask

    task automatic do_clear(input logic v, input logic [NC-1:0] h, input logic fe);
        @(negedge clock);
        clear = 1'b1;
        in_valid = v;
        in_hit = h;
        frame_end = fe;
        @(posedge clock);
        model_zero_all();
        @(negedge clock);
        clear = 1'b0;
        in_valid = 1'b0;
        in_hit = '0;
        frame_end = 1'b0;
        check("clr_counts0", counts0, '0);
        check("clr_counts1", counts1, '0);
        check("clr_flags", {sat0, sat1, busy0, busy1, in_ready0, in_ready1}, 6'b000011);
    endtask

    initial begin
        bit seen;
        model_zero_all();
        p0c = 0; p0n = 0; p0t = 0; p1c = 0; p1n = 0; p1t = 0;

        // Reset, then reset again in the middle of a beat.
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", {in_ready0, in_ready1, busy0, res_valid0, res_valid1}, 5'b11000);
        beat(oh(2));
        beat(oh(2));
        drive(1'b1, oh(5), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_counts0", counts0, '0);
        check("rst_async_counts1", counts1, '0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b1;
        model_zero_all();
        @(negedge clock);
        check("rst_release", {in_ready0, res_valid0, res_tie0, sat0, res_valid1}, 5'b10000);
        check("rst_res", {res_class0, res_count0, res_class1, res_count1}, '0);
        check("rst_counts0", counts0, '0);

        tbl[0] = '{h: {oh(3), oh(7), oh(3), oh(3)},                 cls: 3,  cnt: 3, tie: 0};
        tbl[1] = '{h: {oh(2)|oh(9), oh(2)|oh(9), oh(2)|oh(9), oh(2)|oh(9)}, cls: 2, cnt: 4, tie: 1};
        tbl[2] = '{h: {NC'(0), NC'(0), NC'(0), NC'(0)},               cls: 0,  cnt: 0, tie: 1};
        tbl[3] = '{h: {oh(1)|oh(5), oh(5), oh(1), oh(5)},           cls: 5,  cnt: 3, tie: 0};
        tbl[4] = '{h: {oh(10), oh(10)|oh(0), oh(0), oh(10)},        cls: 10, cnt: 3, tie: 0};
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < 4; j++) beat(tbl[t].h[j]);
            finish_frame(1'b0, '0);
            check("tbl_class", res_class0, tbl[t].cls);
            check("tbl_count", res_count0, tbl[t].cnt);
            check("tbl_tie", res_tie0, tbl[t].tie);
        end

        // Frame end with no beats at all.
        do_clear(1'b0, '0, 1'b0);
        finish_frame(1'b0, '0);
        check("empty_res0", {res_class0, res_count0, res_tie0}, {4'd0, 8'd0, 1'b1});

        // Saturation on the narrow instance.
        do_clear(1'b0, '0, 1'b0);
        repeat (20) beat(oh(5));
        beat(oh(0));
        drive(1'b0, '0, 1'b0);
        check("sat_cnt5_w4", counts1[5*W1 +: W1], 4'd15);
        check("sat_cnt0_w4", counts1[0 +: W1], 4'd1);
        check("sat_cnt5_w8", counts0[5*W0 +: W0], 8'd20);
        check("sat_flags", {sat0, sat1}, 2'b01);
        finish_frame(1'b0, '0);
        check("sat_res1", {res_class1, res_count1, res_tie1}, {4'd5, 4'd15, 1'b0});

        // Beat in the frame-end cycle, then a beat held through the busy window.
        do_clear(1'b0, '0, 1'b0);
        beat(oh(6));
        beat(oh(6));
        start_frame(1'b1, oh(1));
        wait_result(1'b1, oh(8));
        check("same_cycle_res0", {res_class0, res_count0, res_tie0}, {4'd6, 8'd2, 1'b0});
        check("same_cycle_cls1", counts1[1*W1 +: W1], 4'd1);
        check("held_cls8", counts0[8*W0 +: W0], 8'd1);

        // Clear together with a beat and frame end discards both.
        beat(oh(3));
        do_clear(1'b1, oh(3), 1'b1);

        // Clear in scan cycle 4 drops the result.
        beat(oh(4));
        beat(oh(4));
        beat(oh(4));
        start_frame(1'b0, '0);
        repeat (3) drive(1'b0, '0, 1'b0);
        do_clear(1'b0, '0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (res_valid0 === 1'b1 || res_valid1 === 1'b1) seen = 1'b1;
        end
        check("clr_scan_no_strobe", seen, 1'b0);
        check("clr_scan_res0", {res_class0, res_count0, res_tie0}, {CW'(p0c), W0'(p0n), 1'(p0t)});
        check("clr_scan_res1", {res_class1, res_count1, res_tie1}, {CW'(p1c), W1'(p1n), 1'(p1t)});

        // Counts persist across frames when auto-clear is off.
        for (int f = 0; f < 2; f++) begin
            beat(oh(4));
            beat(oh(4));
            finish_frame(1'b0, '0);
        end
        check("persist_count1", res_count1, 4'd4);
        check("persist_count0", res_count0, 8'd2);

        // Random frames with idle gaps and invalid-hit noise.
        do_clear(1'b0, '0, 1'b0);
        for (int f = 0; f < 8; f++) begin
            int nb;
            nb = $urandom_range(0, 8);
            for (int b = 0; b < nb; b++) begin
                logic [NC-1:0] h;
                h = NC'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    beat(h);
                end else begin
                    drive(1'b0, h, 1'b0);
                    @(posedge clock);
                end
            end
            finish_frame(1'($urandom_range(0, 1)), NC'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
